// File: rtl/mem_fill_verify_if.sv
// RAM-side bus of the fill/verify sequencer: write port (waddr/din) and read port (raddr/dout).
// Latency: none, plain wires; the RAM behind it returns dout one cycle after raddr.
// Backpressure: none, the RAM accepts a write and a read on every clock.
interface mem_fill_verify_if #(
    parameter int ADDR_W = 13,
    parameter int WID    = 1
);
    logic [ADDR_W-1:0] waddr;
    logic [WID-1:0]    din;
    logic [ADDR_W-1:0] raddr;
    logic [WID-1:0]    dout;

    // Sequencer side drives addresses and write data, consumes read data.
    modport master (
        output waddr,
        output din,
        output raddr,
        input  dout
    );

    // RAM side.
    modport slave (
        input  waddr,
        input  din,
        input  raddr,
        output dout
    );
endinterface

// File: rtl/mem_fill_verify.sv
// BRAM self-test: fills DEPTH words with a Galois LFSR pattern, reads them back, counts mismatches.
// Latency: run is 2*DEPTH+2 cycles from accepted start to the done pulse; all outputs registered.
// Backpressure: none; start is only taken in IDLE. Optional MEM_FILL_VERIFY_INJECT_EN adds 'inject'.
module mem_fill_verify #(
    parameter int          ADDR_W = 13,
    parameter int          WID    = 1,
    parameter int          DEPTH  = 8192,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef MEM_FILL_VERIFY_INJECT_EN
    input  logic              inject,
`endif
    mem_fill_verify_if.master ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [WID-1:0]    BIT0      = WID'(1);

    // Galois right-shift step, taps x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;

    logic [15:0]       r_lfsr;      // LFSR state of the next word to present
    logic [ADDR_W-1:0] r_waddr;
    logic [WID-1:0]    r_din;
    logic [ADDR_W-1:0] r_raddr;
    logic [WID-1:0]    r_vexp;      // expected word for the address currently on raddr
    logic              r_cmp_vld;   // dout this cycle belongs to a VERIFY read
    logic [WID-1:0]    r_cmp_exp;
    logic [ADDR_W-1:0] r_cmp_addr;

    logic              w_accept;
    logic              w_mismatch;
    logic [ADDR_W:0]   w_err_nxt;
    logic [WID-1:0]    w_word0;

    assign w_accept = (r_state == S_IDLE) && start;

    // Word written at address 0; the inject option corrupts only this one write.
`ifdef MEM_FILL_VERIFY_INJECT_EN
    assign w_word0 = SEED[WID-1:0] ^ (inject ? BIT0 : '0);
`else
    assign w_word0 = SEED[WID-1:0];
`endif

    assign w_mismatch = r_cmp_vld && (ram.dout != r_cmp_exp);
    assign w_err_nxt  = err_count + (ADDR_W+1)'(w_mismatch);

    assign ram.waddr = r_waddr;
    assign ram.din   = r_din;
    assign ram.raddr = r_raddr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: each phase ends once its last address has been presented.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_FILL;
            S_FILL:   if (r_waddr == LAST_ADDR) w_state_nxt = S_VERIFY;
            S_VERIFY: if (r_raddr == LAST_ADDR) w_state_nxt = S_DRAIN;
            S_DRAIN:  w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Address/data generation; outside FILL the write port keeps rewriting the last word with itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr     <= SEED;
            r_waddr    <= '0;
            r_din      <= '0;
            r_raddr    <= '0;
            r_vexp     <= '0;
            r_cmp_vld  <= 1'b0;
            r_cmp_exp  <= '0;
            r_cmp_addr <= '0;
        end else begin
            r_cmp_vld  <= (r_state == S_VERIFY);
            r_cmp_exp  <= r_vexp;
            r_cmp_addr <= r_raddr;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_waddr <= '0;
                        r_din   <= w_word0;
                        r_lfsr  <= lfsr_adv(SEED);
                    end
                end
                S_FILL: begin
                    if (r_waddr == LAST_ADDR) begin
                        r_raddr <= '0;
                        r_vexp  <= SEED[WID-1:0];
                        r_lfsr  <= lfsr_adv(SEED);
                    end else begin
                        r_waddr <= r_waddr + 1'b1;
                        r_din   <= r_lfsr[WID-1:0];
                        r_lfsr  <= lfsr_adv(r_lfsr);
                    end
                end
                S_VERIFY: begin
                    if (r_raddr != LAST_ADDR) begin
                        r_raddr <= r_raddr + 1'b1;
                        r_vexp  <= r_lfsr[WID-1:0];
                        r_lfsr  <= lfsr_adv(r_lfsr);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status: flags follow the next state so they line up with it; results cleared on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            busy <= (w_state_nxt == S_FILL) || (w_state_nxt == S_VERIFY) ||
                    (w_state_nxt == S_DRAIN);
            done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                pass           <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
            end else begin
                if (w_mismatch) begin
                    err_count <= w_err_nxt;
                    if (err_count == '0) first_err_addr <= r_cmp_addr;
                end
                if (r_state == S_DRAIN) pass <= (w_err_nxt == '0);
            end
        end
    end

endmodule
